// File: rtl/fetch.sv
// Instruction-fetch stage: drives a 1-cycle synchronous-read imem,
// holds on stall, redirects on branch/jalr, injects NOP while a jalr waits.
module fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 14,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_wrong,
   input  logic [31:0]       branch_target,
   input  logic              jalr_wait,
   input  logic              jalr_done,
   input  logic [31:0]       jalr_target,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   output logic [31:0]       instr_raw,
   output logic [31:0]       pc_out
);

   localparam logic [0:0] RUN   = 1'b0;
   localparam logic [0:0] JWAIT = 1'b1;

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        req_valid_q, req_valid_d;
   logic [0:0]  state_q, state_d;
   logic [31:0] sel_pc;
   logic [31:0] br_tgt;
   logic [31:0] jr_tgt;

   assign br_tgt = branch_target & ~32'h3;
   assign jr_tgt = jalr_target & ~32'h3;

   // Next-state and memory address; redirects beat stall, stall beats jalr wait.
   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      req_pc_d    = req_pc_q;
      req_valid_d = req_valid_q;
      state_d     = state_q;
      sel_pc      = fetch_pc_q;
      if (branch_wrong) begin
         sel_pc      = br_tgt;
         req_pc_d    = br_tgt;
         fetch_pc_d  = br_tgt + 32'd4;
         req_valid_d = 1'b1;
         state_d     = RUN;
      end else if (jalr_done) begin
         sel_pc      = jr_tgt;
         req_pc_d    = jr_tgt;
         fetch_pc_d  = jr_tgt + 32'd4;
         req_valid_d = 1'b1;
         state_d     = RUN;
      end else if (stall) begin
         sel_pc = req_pc_q;
      end else if (jalr_wait || state_q == JWAIT) begin
         sel_pc      = fetch_pc_q;
         req_valid_d = 1'b0;
         state_d     = JWAIT;
      end else begin
         sel_pc      = fetch_pc_q;
         req_pc_d    = fetch_pc_q;
         fetch_pc_d  = fetch_pc_q + 32'd4;
         req_valid_d = 1'b1;
      end
   end

   // Fetch state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q  <= RESET_PC;
         req_pc_q    <= 32'd0;
         req_valid_q <= 1'b0;
         state_q     <= RUN;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         req_pc_q    <= req_pc_d;
         req_valid_q <= req_valid_d;
         state_q     <= state_d;
      end
   end

   assign imem_addr = ADDR_W'(sel_pc >> 2);
   assign instr_raw = req_valid_q ? imem_data : NOP;
   assign pc_out    = req_pc_q;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: imem model, decoder-view reference model
// compared every cycle, plus literal expectations along the sequence.
module tb_fetch;
   localparam int          AW    = 14;
   localparam int          DEPTH = 1 << AW;
   localparam logic [31:0] NOPI  = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          stall = 1'b0;
   logic          branch_wrong = 1'b0;
   logic [31:0]   branch_target = 32'd0;
   logic          jalr_wait = 1'b0;
   logic          jalr_done = 1'b0;
   logic [31:0]   jalr_target = 32'd0;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_data;
   logic [31:0]   instr_raw;
   logic [31:0]   pc_out;

   logic [31:0] mem [DEPTH];

   int n_checks = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   fetch #(
      .RESET_PC(32'h0),
      .ADDR_W(AW),
      .NOP(NOPI)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .branch_wrong(branch_wrong),
      .branch_target(branch_target),
      .jalr_wait(jalr_wait),
      .jalr_done(jalr_done),
      .jalr_target(jalr_target),
      .imem_addr(imem_addr),
      .imem_data(imem_data),
      .instr_raw(instr_raw),
      .pc_out(pc_out)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i + 1);
   end

   always @(posedge clk) imem_data <= mem[imem_addr];

   // Reference: what the decoder sees. shown_pc/shown_real describe the
   // instruction on display; next_pc is the sequential successor;
   // waiting means a jalr target is outstanding.
   logic [31:0] shown_pc = 32'd0;
   bit          shown_real = 1'b0;
   logic [31:0] next_pc = 32'd0;
   bit          waiting = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         shown_pc = 32'd0; shown_real = 0; next_pc = 32'd0; waiting = 0;
      end else if (branch_wrong || jalr_done) begin
         shown_pc = (branch_wrong ? branch_target : jalr_target) & ~32'h3;
         shown_real = 1; next_pc = shown_pc + 4; waiting = 0;
      end else if (stall) begin
         // decoder keeps looking at the same instruction
      end else if (jalr_wait || waiting) begin
         shown_real = 0; waiting = 1;
      end else begin
         shown_pc = next_pc; shown_real = 1; next_pc = next_pc + 4;
      end
   end

   function automatic logic [31:0] word_at(logic [31:0] pc);
      return mem[int'((pc >> 2) % DEPTH)];
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         logic [31:0] ei;
         ei = shown_real ? word_at(shown_pc) : NOPI;
         n_checks++;
         if (instr_raw !== ei || pc_out !== shown_pc) begin
            n_fail++;
            $display("FAIL model t=%0t instr=%h/%h pc=%h/%h (got/exp)",
                     $time, instr_raw, ei, pc_out, shown_pc);
         end
      end
   end

   task automatic chk(string nm, logic [31:0] ei, logic [31:0] ep);
      n_checks++;
      if (instr_raw !== ei || pc_out !== ep) begin
         n_fail++;
         $display("FAIL %s instr=%h exp %h pc=%h exp %h",
                  nm, instr_raw, ei, pc_out, ep);
      end
   endtask

   task automatic nx();
      @(negedge clk);
   endtask

   initial begin
      nx(); cmp_en = 1'b1;
      nx(); nx();
      chk("reset", NOPI, 32'h0);
      rst = 1'b0;
      nx(); chk("s0", 32'd1, 32'h0);
      nx(); chk("s1", 32'd2, 32'h4);
      nx(); chk("s2", 32'd3, 32'h8);
      stall = 1'b1;
      nx(); chk("stl1", 32'd3, 32'h8);
      nx(); chk("stl2", 32'd3, 32'h8);
      nx(); chk("stl3", 32'd3, 32'h8);
      stall = 1'b0;
      nx(); chk("stl_rel", 32'd4, 32'hC);
      branch_wrong = 1'b1; branch_target = 32'h40;
      nx(); chk("br", 32'd17, 32'h40);
      branch_wrong = 1'b0;
      nx(); chk("br_nx", 32'd18, 32'h44);
      branch_wrong = 1'b1; branch_target = 32'h43;
      nx(); chk("br_align", 32'd17, 32'h40);
      branch_wrong = 1'b0;
      nx(); chk("br_al_nx", 32'd18, 32'h44);
      jalr_wait = 1'b1;
      nx(); chk("jw1", NOPI, 32'h44);
      jalr_wait = 1'b0;
      nx(); chk("jw2", NOPI, 32'h44);
      nx(); chk("jw3", NOPI, 32'h44);
      jalr_done = 1'b1; jalr_target = 32'h100;
      nx(); chk("jd", 32'd65, 32'h100);
      jalr_done = 1'b0;
      stall = 1'b1; branch_wrong = 1'b1; branch_target = 32'h80;
      nx(); chk("stbr1", 32'd33, 32'h80);
      branch_wrong = 1'b0;
      nx(); chk("stbr2", 32'd33, 32'h80);
      nx(); chk("stbr3", 32'd33, 32'h80);
      stall = 1'b0;
      nx(); chk("stbr_nx", 32'd34, 32'h84);
      branch_wrong = 1'b1; branch_target = 32'h200;
      jalr_done = 1'b1; jalr_target = 32'h300;
      nx(); chk("br_vs_jd", 32'd129, 32'h200);
      branch_wrong = 1'b0; jalr_done = 1'b0;
      jalr_wait = 1'b1;
      nx(); chk("jw_a", NOPI, 32'h200);
      jalr_wait = 1'b0;
      nx(); chk("jw_b", NOPI, 32'h200);
      rst = 1'b1;
      nx(); chk("rst_mid", NOPI, 32'h0);
      rst = 1'b0;
      nx(); chk("rs0", 32'd1, 32'h0);
      nx(); chk("rs1", 32'd2, 32'h4);
      jalr_wait = 1'b1; jalr_done = 1'b1; jalr_target = 32'h10;
      nx(); chk("jw_jd", 32'd5, 32'h10);
      jalr_wait = 1'b0; jalr_done = 1'b0;
      nx(); chk("jw_jd_nx", 32'd6, 32'h14);
      branch_wrong = 1'b1; branch_target = 32'hFFFF_FFFC;
      nx(); chk("top", 32'h4000, 32'hFFFF_FFFC);
      branch_wrong = 1'b0;
      nx(); chk("wrap", 32'd1, 32'h0);
      jalr_wait = 1'b1;
      nx(); chk("jst0", NOPI, 32'h0);
      jalr_wait = 1'b0; stall = 1'b1;
      nx(); chk("jst1", NOPI, 32'h0);
      stall = 1'b0;
      nx(); chk("jst2", NOPI, 32'h0);
      jalr_done = 1'b1; jalr_target = 32'h8;
      nx(); chk("jst_done", 32'd3, 32'h8);
      jalr_done = 1'b0;
      nx(); chk("jst_nx", 32'd4, 32'hC);
      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
